strobe_sink: RTL and testbench

//   Receiving end of the periodic valid-strobe interface: samples in_data on each in_valid pulse
//   (nominally one pulse every PERIOD cycles), buffers it in a 2-entry FIFO, and presents it

---
 rtl/strobe_sink.sv | 210 +++++++++++++++++++++
 tb/tb_strobe_sink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_sink.sv
// Receiver for a periodic valid-strobe link: 2-entry FIFO toward a valid/ready sink plus strobe-spacing lock checker.
// Optional STROBE_ERR_CNT_EN adds err_cnt[7:0], a saturating count of period_err and overflow pulses.
module strobe_sink #(
  parameter int DATA_W   = 8,
  parameter int PERIOD   = 5,
  parameter int LOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              locked,
  output logic              period_err,
  output logic              overflow
`ifdef STROBE_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int GAP_W  = $clog2(PERIOD + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(PERIOD);
  localparam logic [GAP_W-1:0]  GAP_REF   = GAP_W'(PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                locked_q, locked_d;
  logic                period_err_q, period_err_d;
  logic                overflow_q, overflow_d;

  logic [DATA_W-1:0]   mem_q [2];
  logic [DATA_W-1:0]   mem_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                good_iv;
  logic                early;
  logic                missing;
  logic                err_ev;
  logic                pop;
  logic                push;
  logic                drop;

  // Interval classification relative to the last strobe
  always_comb begin
    good_iv = in_valid && (gap_q == GAP_REF);
    early   = in_valid && (gap_q < GAP_REF);
    missing = !in_valid && (gap_q == GAP_REF);
  end

  always_comb begin
    gap_d = gap_q;
    if (in_valid) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_ev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOCKING;
          good_d  = '0;
        end
      end
      ST_LOCKING: begin
        if (good_iv) begin
          if (good_q >= GOOD_LAST) begin
            good_d  = GOOD_MAX;
            state_d = ST_LOCKED;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else if (early) begin
          err_ev = 1'b1;
          good_d = '0;
        end else if (missing) begin
          err_ev  = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (early) begin
          err_ev  = 1'b1;
          good_d  = '0;
          state_d = ST_LOCKING;
        end else if (missing) begin
          err_ev  = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase
  end

  // Registered status outputs
  always_comb begin
    locked_d     = (state_d == ST_LOCKED);
    period_err_d = err_ev;
    overflow_d   = drop;
  end

  // FIFO: a pop in the same cycle frees a slot for the incoming strobe
  always_comb begin
    pop      = (count_q != 2'd0) && out_ready;
    push     = in_valid && ((count_q != 2'd2) || pop);
    drop     = in_valid && !push;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      overflow_q   <= overflow_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = mem_q[rd_ptr_q];
  assign locked     = locked_q;
  assign period_err = period_err_q;
  assign overflow   = overflow_q;

`ifdef STROBE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  // Both pulses in one cycle add two; clamp at 255
  always_comb begin
    err_sum = {1'b0, err_cnt_q} + 9'(err_ev) + 9'(drop);
    if (err_sum > 9'd255) begin
      err_cnt_d = 8'hFF;
    end else begin
      err_cnt_d = err_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_strobe_sink.sv
// Bench for strobe_sink: directed scenarios then randomized strobe spacing, checked against an interval-based model.
module tb_strobe_sink;

  localparam int DATA_W   = 8;
  localparam int PERIOD   = 5;
  localparam int LOCK_CNT = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              locked;
  logic              period_err;
  logic              overflow;
`ifdef STROBE_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  strobe_sink #(.DATA_W(DATA_W), .PERIOD(PERIOD), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .locked     (locked),
    .period_err (period_err),
    .overflow   (overflow)
`ifdef STROBE_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time of last strobe, lock mode (0 idle, 1 locking, 2 locked), FIFO as a queue
  int                cyc;
  int                last_strobe;
  int                mode;
  int                good;
  logic [DATA_W-1:0] q [$];
  logic              exp_locked;
  logic              exp_perr;
  logic              exp_ovf;
  int                exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc         = 0;
    last_strobe = -1;
    mode        = 0;
    good        = 0;
    exp_locked  = 1'b0;
    exp_perr    = 1'b0;
    exp_ovf     = 1'b0;
    exp_err     = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    check({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    check({tag, ".period_err"}, 32'(period_err), 32'(exp_perr));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef STROBE_ERR_CNT_EN
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
`endif
  endtask

  // One clock cycle: drive, check at negedge, then advance the model across the posedge
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d, input logic r);
    int   k;
    logic perr;
    logic ovf;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    check_outputs(tag);
    if (q.size() > 0 && r) void'(q.pop_front());
    ovf = 1'b0;
    if (v) begin
      if (q.size() < 2) q.push_back(d);
      else ovf = 1'b1;
    end
    k    = cyc - last_strobe;
    perr = 1'b0;
    if (v) begin
      if (mode == 0) begin
        mode = 1;
        good = 0;
      end else if (k < PERIOD) begin
        perr = 1'b1;
        mode = 1;
        good = 0;
      end else if (mode == 1) begin
        good++;
        if (good >= LOCK_CNT) mode = 2;
      end
      last_strobe = cyc;
    end else if (k == PERIOD && mode != 0) begin
      perr = 1'b1;
      mode = 0;
    end
    cyc++;
    exp_perr   = perr;
    exp_ovf    = ovf;
    exp_locked = (mode == 2);
    exp_err    = exp_err + int'(perr) + int'(ovf);
    if (exp_err > 255) exp_err = 255;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n, input logic r);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    logic [DATA_W-1:0] dv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.locked", 32'(locked), 32'd0);
    check("reset.period_err", 32'(period_err), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
`ifdef STROBE_ERR_CNT_EN
    check("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // 1: steady 5-cycle strobes lock after the 4th strobe
    for (int i = 0; i < 6; i++) begin
      dv = DATA_W'(8'h11 * (i + 1));
      step("t1", 1'b1, dv, 1'b1);
      idle("t1", PERIOD - 1, 1'b1);
    end
    check("t1.locked_final", 32'(locked), 32'd1);

    // 2: early strobe drops lock, three good intervals regain it
    step("t2", 1'b1, 8'h5A, 1'b1);
    idle("t2", 2, 1'b1);
    step("t2", 1'b1, 8'h5B, 1'b1);
    check("t2.locked_after_early", 32'(locked), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle("t2", PERIOD - 1, 1'b1);
      step("t2", 1'b1, DATA_W'(8'h60 + i), 1'b1);
    end
    idle("t2", 1, 1'b1);
    check("t2.relocked", 32'(locked), 32'd1);

    // 3: missing strobe goes idle; a late strobe restarts locking silently
    idle("t3", PERIOD + 4, 1'b1);
    check("t3.unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step("t3", 1'b1, DATA_W'(8'h70 + i), 1'b1);
      idle("t3", PERIOD - 1, 1'b1);
    end

    // 4: overflow with out_ready low, then drain in order
    step("t4", 1'b1, 8'hA1, 1'b0);
    idle("t4", PERIOD - 1, 1'b0);
    step("t4", 1'b1, 8'hA2, 1'b0);
    idle("t4", PERIOD - 1, 1'b0);
    step("t4", 1'b1, 8'hA3, 1'b0);
    step("t4", 1'b0, '0, 1'b0);
    idle("t4", 4, 1'b1);

    // 5: full FIFO with simultaneous pop and strobe accepts the new datum
    step("t5", 1'b1, 8'hB1, 1'b0);
    idle("t5", PERIOD - 1, 1'b0);
    step("t5", 1'b1, 8'hB2, 1'b0);
    idle("t5", PERIOD - 1, 1'b0);
    step("t5", 1'b1, 8'hB3, 1'b1);
    idle("t5", 4, 1'b1);

    // 6: async reset while locked with two buffered entries
    for (int i = 0; i < 5; i++) begin
      step("t6", 1'b1, DATA_W'(8'hC0 + i), 1'b1);
      idle("t6", PERIOD - 1, 1'b1);
    end
    step("t6", 1'b1, 8'hC8, 1'b0);
    idle("t6", PERIOD - 1, 1'b0);
    step("t6", 1'b1, 8'hC9, 1'b0);
    check("t6.pre_locked", 32'(locked), 32'd1);
    check("t6.pre_full", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst_out_valid", 32'(out_valid), 32'd0);
    check("t6.rst_out_data", 32'(out_data), 32'd0);
    check("t6.rst_locked", 32'(locked), 32'd0);
    check("t6.rst_period_err", 32'(period_err), 32'd0);
    check("t6.rst_overflow", 32'(overflow), 32'd0);
`ifdef STROBE_ERR_CNT_EN
    check("t6.rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle("t6.post", 3, 1'b1);

    // Error counter saturation: back-to-back strobes are all early
    for (int i = 0; i < 302; i++) step("sat", 1'b1, DATA_W'(i), 1'b1);
    idle("sat", PERIOD + 2, 1'b1);
`ifdef STROBE_ERR_CNT_EN
    check("sat.err_cnt", 32'(err_cnt), 32'd255);
`endif

    // Randomized spacing and back-pressure
    nxt = 0;
    for (int i = 0; i < 500; i++) begin
      if (nxt == 0) begin
        step("rand", 1'b1, DATA_W'($urandom), ($urandom_range(0, 3) != 0));
        nxt = ($urandom_range(0, 3) != 0) ? PERIOD - 1 : int'($urandom_range(0, 7));
      end else begin
        step("rand", 1'b0, DATA_W'($urandom), ($urandom_range(0, 3) != 0));
        nxt--;
      end
    end
    idle("drain", 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
